// File: rtl/mod_cu.sv
// mod_cu: Moore control unit sequencing a repeated-subtraction modulus datapath,
// counting subtractions as the quotient and flagging divide-by-zero / iteration-limit errors.
module mod_cu #(
  parameter int          QW       = 16,
  parameter int unsigned MAX_ITER = 32'h0000_FFFF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic          b_zero,
  input  logic          ltb,
  output logic          we,
  output logic          selA,
  output logic          saveSub,
  output logic          saveResult,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [QW-1:0] quotient
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_UPD,
    S_SAVE,
    S_DONE,
    S_ERR
  } state_t;
  state_t        r_state;
  state_t        w_next;
  logic [QW-1:0] r_quotient;
  logic          r_err;
  logic          w_accept;
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = !start ? S_IDLE : (b_zero ? S_ERR : S_LOAD);
      S_LOAD:  w_next = S_CMP;
      // The limit check precedes the increment in UPD, so the counter never wraps.
      S_CMP:   w_next = ltb ? S_SAVE : (r_quotient == QW'(MAX_ITER) ? S_ERR : S_UPD);
      S_UPD:   w_next = S_CMP;
      S_SAVE:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  assign w_accept = (r_state == S_IDLE) && start;
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_quotient <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept)              r_quotient <= '0;
      else if (r_state == S_UPD) r_quotient <= r_quotient + 1'b1;
      // err is registered on entry to ERR so it is already high during the ERR cycle.
      if (w_next == S_ERR)            r_err <= 1'b1;
      else if (w_accept && !b_zero)   r_err <= 1'b0;
    end
  end
  assign we         = (r_state == S_LOAD) || (r_state == S_UPD);
  assign selA       = (r_state == S_LOAD);
  assign saveSub    = (r_state == S_CMP);
  assign saveResult = (r_state == S_SAVE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE) || (r_state == S_ERR);
  assign err        = r_err;
  assign quotient   = r_quotient;
endmodule

// File: tb/tb_mod_cu.sv
// tb_mod_cu: drives two control units (default limit and limit 3) each paired with a
// behavioural datapath, checking cycle timing, strobe counts and results against a/b arithmetic.
module tb_mod_cu;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  logic b_zero = 1'b0;
  logic st[2];
  logic ltb[2], we[2], selA[2], saveSub[2], saveResult[2], busy[2], done[2], err[2];
  logic [15:0] quo[2];
  logic signed [31:0] a = 0, b = 1;
  logic signed [31:0] tmp[2], sub[2], res[2];
  int n_tests = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  mod_cu u0 (
    .CLK(CLK), .reset(reset), .start(st[0]), .b_zero(b_zero), .ltb(ltb[0]),
    .we(we[0]), .selA(selA[0]), .saveSub(saveSub[0]), .saveResult(saveResult[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .quotient(quo[0])
  );
  mod_cu #(.QW(16), .MAX_ITER(3)) u1 (
    .CLK(CLK), .reset(reset), .start(st[1]), .b_zero(b_zero), .ltb(ltb[1]),
    .we(we[1]), .selA(selA[1]), .saveSub(saveSub[1]), .saveResult(saveResult[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .quotient(quo[1])
  );

  always_comb begin
    for (int g = 0; g < 2; g++) ltb[g] = (tmp[g] - b) < 0;
  end
  always_ff @(posedge CLK) begin
    for (int g = 0; g < 2; g++) begin
      if (we[g]) tmp[g] <= selA[g] ? a : sub[g];
      if (saveSub[g]) sub[g] <= tmp[g] - b;
      if (saveResult[g]) res[g] <= tmp[g];
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic op(input int s, input int aa, input int bb, input bit bz, input bit poke);
    int q, m, ecyc, eq, ee, ewe, esub, eres;
    int nwe = 0, nsub = 0, nres = 0, rcyc = 0, dc = 0, bad_busy = 0, c = 1, dq = -1, de = -1;
    logic signed [31:0] rval = 0;
    m = (s == 1) ? 3 : 65535;
    if (bz) begin
      ecyc = 1; eq = 0; ee = 1; ewe = 0; esub = 0; eres = 0;
    end else begin
      q = aa / bb;
      if (q > m) begin
        ecyc = 2 * m + 3; eq = m; ee = 1; ewe = m + 1; esub = m + 1; eres = 0;
      end else begin
        ecyc = 2 * q + 4; eq = q; ee = 0; ewe = q + 1; esub = q + 1; eres = 1;
      end
    end
    a = aa; b = bb; b_zero = bz; st[s] = 1'b1;
    @(negedge CLK);
    st[s] = 1'b0; b_zero = 1'b0;
    while (dc == 0 && c <= 300) begin
      if (c == 1) begin
        chk("err_cycle1", err[s], bz);
        chk("quotient_cleared", quo[s], 0);
      end
      nwe += int'(we[s]);
      nsub += int'(saveSub[s]);
      if (saveResult[s]) begin nres++; rcyc = c; rval = tmp[s]; end
      if (busy[s] !== 1'b1) bad_busy++;
      if (done[s] === 1'b1) begin
        dc = c; dq = int'(quo[s]); de = int'(err[s]);
      end else begin
        st[s] = poke && (c == 2 || c == 5);
        @(negedge CLK);
        c++;
      end
    end
    st[s] = 1'b0;
    chk("done_cycle", dc, ecyc);
    chk("quotient_at_done", dq, eq);
    chk("err_at_done", de, ee);
    chk("we_strobes", nwe, ewe);
    chk("saveSub_strobes", nsub, esub);
    chk("saveResult_strobes", nres, eres);
    chk("busy_low_while_active", bad_busy, 0);
    if (eres == 1) begin
      chk("saveResult_cycle", rcyc, ecyc - 1);
      chk("result_temp", rval, aa % bb);
    end
    @(negedge CLK);
    chk("idle_busy", busy[s], 0);
    chk("idle_done", done[s], 0);
    chk("quotient_held", quo[s], eq);
    chk("err_sticky", err[s], ee);
  endtask

  initial begin
    st[0] = 1'b0; st[1] = 1'b0;
    repeat (2) @(negedge CLK);
    for (int g = 0; g < 2; g++) begin
      chk("reset_busy", busy[g], 0);
      chk("reset_done", done[g], 0);
      chk("reset_err", err[g], 0);
      chk("reset_we", we[g], 0);
      chk("reset_quotient", quo[g], 0);
    end
    reset = 1'b0;
    @(negedge CLK);
    op(0, 7, 3, 1'b0, 1'b0);
    op(0, 2, 5, 1'b0, 1'b0);
    op(0, 0, 0, 1'b1, 1'b0);
    repeat (3) begin
      chk("err_holds_idle", err[0], 1);
      chk("busy_idle_after_err", busy[0], 0);
      @(negedge CLK);
    end
    op(0, 13, 4, 1'b0, 1'b0);
    op(1, 100, 1, 1'b0, 1'b0);
    op(1, 12, 4, 1'b0, 1'b0);
    op(1, 16, 4, 1'b0, 1'b0);
    op(0, 9, 2, 1'b0, 1'b1);
    op(0, 9, 2, 1'b0, 1'b0);
    // Abort in cycle 3 (UPD) with an asynchronous reset.
    a = 9; b = 2; st[0] = 1'b1;
    @(negedge CLK);
    st[0] = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    #1;
    chk("async_rst_we", we[0], 0);
    chk("async_rst_selA", selA[0], 0);
    chk("async_rst_saveSub", saveSub[0], 0);
    chk("async_rst_saveResult", saveResult[0], 0);
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_done", done[0], 0);
    chk("async_rst_err", err[0], 0);
    chk("async_rst_quotient", quo[0], 0);
    repeat (3) begin
      @(negedge CLK);
      chk("no_done_in_reset", done[0], 0);
    end
    reset = 1'b0;
    @(negedge CLK);
    op(0, 9, 2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) op(0, int'($urandom_range(0, 60)), int'($urandom_range(1, 9)), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) op(1, int'($urandom_range(0, 30)), int'($urandom_range(1, 8)), 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_cu.md
# mod_cu

Control unit for the repeated-subtraction modulus datapath. It sequences the datapath's `we`, `selA`, `saveSub` and `saveResult` strobes from a start/done handshake and reacts to the datapath's `ltb` (difference-negative) flag. It also counts subtractions to report the quotient, and flags divide-by-zero and iteration-limit errors. It sits between the top-level requester and the modulus datapath; the datapath is instantiated alongside it, not inside it.

## Interface
- `QW`, 16: quotient/iteration counter width.
- `MAX_ITER`, 16'hFFFF: maximum number of subtractions before abort; must be ≤ 2^QW − 1.

- `CLK`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `b_zero`  in  1  divisor equals zero (from requester, valid while `start` high).
- `ltb`  in  1  datapath flag: current temp − b is negative.
- `we`  out  1  datapath temp write enable.
- `selA`  out  1  datapath temp source: 1 = operand a, 0 = saved difference.
- `saveSub`  out  1  datapath capture of difference.
- `saveResult`  out  1  datapath capture of result (temp).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky error flag, valid with `done`; cleared on next accepted start.
- `quotient`  out  QW  number of completed subtractions; held after done.

## Operation
- Moore FSM. States: IDLE, LOAD, CMP, UPD, SAVE, DONE, ERR. All datapath strobes decode from state only.
- IDLE: all strobes 0, `busy`=0.
  - `start`=1 and `b_zero`=0: go to LOAD, clear `quotient` and `err`.
  - `start`=1 and `b_zero`=1: go to ERR, clear `quotient`.
  - Otherwise stay.
- LOAD: `we`=1, `selA`=1 (temp ← a). Go to CMP.
- CMP: `saveSub`=1 (subReg ← temp − b).
  - `ltb`=1: go to SAVE.
  - `ltb`=0 and `quotient` = MAX_ITER: go to ERR.
  - Otherwise go to UPD.
- UPD: `we`=1, `selA`=0 (temp ← subReg). `quotient` increments by 1. Go to CMP.
- SAVE: `saveResult`=1 (result ← temp). Go to DONE.
- DONE: `done`=1, `err`=0. Go to IDLE.
- ERR: `done`=1, `err` set to 1. Go to IDLE; `err` stays 1 in IDLE until the next accepted start.
- Operands are signed 32-bit values, as `ltb` is the datapath's sign bit. Behaviour is defined only for a ≥ 0 and b > 0.
- `start` while `busy` is ignored. No queuing.
- `quotient` never wraps: the MAX_ITER check happens in CMP, before any increment.

## Timing
- Reset (asynchronous, immediate): state = IDLE; `we`, `selA`, `saveSub`, `saveResult`, `busy`, `done`, `err` = 0; `quotient` = 0.
- Let edge 0 be the edge that samples `start`=1 in IDLE, and q = a div b. LOAD occupies cycle 1; `done` is high in cycle 2q+4; IDLE is reached in cycle 2q+5, when a new start may be sampled.
- Divide-by-zero: ERR in cycle 1, `done`=`err`=1 in cycle 1, IDLE in cycle 2.
- Iteration abort: with MAX_ITER = M, ERR is entered from the (M+1)th CMP, in cycle 2M+3; `done`=`err`=1 in that cycle; `quotient` = M.
- `ltb` is sampled at the end of CMP, one cycle after temp was written.
- `busy` rises in cycle 1 and falls on entry to IDLE.
- Reset asserted mid-operation aborts immediately. No `done` is produced, and the datapath registers are left as-is.

## Test plan
- a=7, b=3: `done` at cycle 8, `quotient`=2, `err`=0; `saveResult` strobe in cycle 7 with datapath temp=1.
- a=2, b=5: sequence LOAD, CMP, SAVE, DONE; `done` at cycle 4, `quotient`=0, result=2.
- `b_zero`=1 with `start`: `done`=`err`=1 in cycle 1; no `we`/`saveSub` strobes; `err` holds through IDLE until the next start with b=4 clears it.
- MAX_ITER=3, a=100, b=1: ERR at cycle 9, `quotient`=3, `err`=1, no `saveResult` strobe.
- `start` pulses during busy (a=9, b=2): ignored; single `done` at cycle 12 with `quotient`=4; back-to-back start accepted at cycle 13.
- `reset` asserted at cycle 3 of a=9, b=2: all outputs 0 asynchronously; FSM in IDLE; no `done` pulse.
